// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and limits for the multi-approach traffic controller
package traffic_pkg;

    localparam int MAX_PHASES = 8;

    typedef logic [7:0] sec_t;

    typedef enum logic [2:0] {
        ST_GREEN  = 3'd0,
        ST_YELLOW = 3'd1,
        ST_ALLRED = 3'd2,
        ST_WALK   = 3'd3,
        ST_NIGHT  = 3'd4
    } tlc_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a one-cycle tick every CLK_HZ cycles
module tick_prescaler #(
    parameter int CLK_HZ = 12000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// rtl/traffic_ctrl_multi.sv - round-robin multi-approach light sequencer with pedestrian WALK; TLC_NIGHT_MODE_EN adds flashing-yellow night mode
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int NUM_PHASES = 2,
    parameter int GREEN_S    = 5,
    parameter int YELLOW_S   = 2,
    parameter int ALLRED_S   = 1,
    parameter int PED_S      = 5,
    localparam int PW        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] ped_req_n,
`ifdef TLC_NIGHT_MODE_EN
    input  logic                  night_mode,
`endif
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] ped_red,
    output logic [NUM_PHASES-1:0] ped_green,
    output logic [PW-1:0]         phase,
    output logic [7:0]            sec_left,
    output logic [NUM_PHASES-1:0] ped_pending
);

    if (CLK_HZ < 2 || NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES ||
        GREEN_S < 1 || GREEN_S > 255 || YELLOW_S < 1 || YELLOW_S > 255 ||
        ALLRED_S < 1 || ALLRED_S > 255 || PED_S < 1 || PED_S > 255) begin : g_param_err
        $error("traffic_ctrl_multi: parameter out of range");
    end

    localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

    tlc_state_e            state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    sec_t                  sec_q, sec_d;
    logic [NUM_PHASES-1:0] ped_s1_q, ped_s1_d, ped_s2_q, ped_s2_d;
    logic [NUM_PHASES-1:0] ped_pending_q, ped_pending_d;
    logic [NUM_PHASES-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
    logic [NUM_PHASES-1:0] ped_red_q, ped_red_d, ped_green_q, ped_green_d;
    logic [NUM_PHASES-1:0] sel, walk_clr;
    logic [PW-1:0]         phase_next;
    logic                  tick, presc_clr, walk_entry;
`ifdef TLC_NIGHT_MODE_EN
    logic                  night_s1_q, night_s1_d, night_s2_q, night_s2_d;
    logic                  night_exit_q, night_exit_d;
`endif

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (presc_clr),
        .tick  (tick)
    );

    assign phase_next = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sec_d      = sec_q;
        presc_clr  = 1'b0;
        walk_entry = 1'b0;
        ped_s1_d   = ped_req_n;
        ped_s2_d   = ped_s1_q;
`ifdef TLC_NIGHT_MODE_EN
        night_s1_d   = night_mode;
        night_s2_d   = night_s1_q;
        night_exit_d = night_exit_q;
`endif
        if (tick) begin
            if (sec_q == sec_t'(1)) begin
                presc_clr = 1'b1;
                case (state_q)
                    ST_GREEN: begin
                        state_d = ST_YELLOW;
                        sec_d   = sec_t'(YELLOW_S);
                    end
                    ST_YELLOW: begin
                        state_d = ST_ALLRED;
                        sec_d   = sec_t'(ALLRED_S);
                    end
                    ST_ALLRED: begin
`ifdef TLC_NIGHT_MODE_EN
                        if (night_exit_q) begin
                            state_d      = ST_GREEN;
                            phase_d      = '0;
                            sec_d        = sec_t'(GREEN_S);
                            night_exit_d = 1'b0;
                        end else
`endif
                        if (ped_pending_q[phase_q]) begin
                            state_d    = ST_WALK;
                            sec_d      = sec_t'(PED_S);
                            walk_entry = 1'b1;
                        end else begin
                            state_d = ST_GREEN;
                            phase_d = phase_next;
                            sec_d   = sec_t'(GREEN_S);
                        end
                    end
                    ST_WALK: begin
                        state_d = ST_GREEN;
                        phase_d = phase_next;
                        sec_d   = sec_t'(GREEN_S);
                    end
                    default: ;
                endcase
            end else begin
                sec_d = sec_q - sec_t'(1);
            end
        end
`ifdef TLC_NIGHT_MODE_EN
        // Night overrides every sequencing decision; leaving it restarts at phase 0 via all-red.
        if (night_s2_q) begin
            state_d      = ST_NIGHT;
            phase_d      = '0;
            sec_d        = '0;
            walk_entry   = 1'b0;
            night_exit_d = 1'b0;
            presc_clr    = (state_q != ST_NIGHT);
        end else if (state_q == ST_NIGHT) begin
            state_d      = ST_ALLRED;
            phase_d      = '0;
            sec_d        = sec_t'(ALLRED_S);
            night_exit_d = 1'b1;
            presc_clr    = 1'b1;
        end
`endif
        // Set is ORed in after the clear so a coincident press survives WALK entry.
        walk_clr = '0;
        if (walk_entry) begin
            walk_clr[phase_q] = 1'b1;
        end
        ped_pending_d = (ped_pending_q & ~walk_clr) | ~ped_s2_q;

        sel          = '0;
        sel[phase_d] = 1'b1;
        red_d        = '1;
        yellow_d     = '0;
        green_d      = '0;
        ped_red_d    = '1;
        ped_green_d  = '0;
        case (state_d)
            ST_GREEN: begin
                green_d = sel;
                red_d   = ~sel;
            end
            ST_YELLOW: begin
                yellow_d = sel;
                red_d    = ~sel;
            end
            ST_WALK: begin
                ped_green_d = sel;
                ped_red_d   = ~sel;
            end
`ifdef TLC_NIGHT_MODE_EN
            ST_NIGHT: begin
                red_d         = '0;
                ped_red_d     = '0;
                ped_pending_d = '0;
                if (state_q != ST_NIGHT) begin
                    yellow_d = '1;
                end else begin
                    yellow_d = tick ? ~yellow_q : yellow_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_GREEN;
            phase_q       <= '0;
            sec_q         <= sec_t'(GREEN_S);
            ped_s1_q      <= '1;
            ped_s2_q      <= '1;
            ped_pending_q <= '0;
            red_q         <= ~NUM_PHASES'(1);
            yellow_q      <= '0;
            green_q       <= NUM_PHASES'(1);
            ped_red_q     <= '1;
            ped_green_q   <= '0;
`ifdef TLC_NIGHT_MODE_EN
            night_s1_q    <= 1'b0;
            night_s2_q    <= 1'b0;
            night_exit_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            sec_q         <= sec_d;
            ped_s1_q      <= ped_s1_d;
            ped_s2_q      <= ped_s2_d;
            ped_pending_q <= ped_pending_d;
            red_q         <= red_d;
            yellow_q      <= yellow_d;
            green_q       <= green_d;
            ped_red_q     <= ped_red_d;
            ped_green_q   <= ped_green_d;
`ifdef TLC_NIGHT_MODE_EN
            night_s1_q    <= night_s1_d;
            night_s2_q    <= night_s2_d;
            night_exit_q  <= night_exit_d;
`endif
        end
    end

    assign red         = red_q;
    assign yellow      = yellow_q;
    assign green       = green_q;
    assign ped_red     = ped_red_q;
    assign ped_green   = ped_green_q;
    assign phase       = phase_q;
    assign sec_left    = sec_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb/tb_traffic_ctrl_multi.sv - directed self-checking bench for traffic_ctrl_multi
module tb_traffic_ctrl_multi;

    logic       clk;
    logic       reset;
    logic [1:0] ped_req_n;
    logic [1:0] red, yellow, green, ped_red, ped_green, ped_pending;
    logic [0:0] phase;
    logic [7:0] sec_left;
`ifdef TLC_NIGHT_MODE_EN
    logic       night_mode;
`endif

    int checks = 0;
    int errors = 0;
    int t      = 0;

    traffic_ctrl_multi #(
        .CLK_HZ     (4),
        .NUM_PHASES (2),
        .GREEN_S    (3),
        .YELLOW_S   (2),
        .ALLRED_S   (1),
        .PED_S      (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ped_req_n   (ped_req_n),
`ifdef TLC_NIGHT_MODE_EN
        .night_mode  (night_mode),
`endif
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .ped_red     (ped_red),
        .ped_green   (ped_green),
        .phase       (phase),
        .sec_left    (sec_left),
        .ped_pending (ped_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // t counts falling edges since reset release; outputs are sampled there.
    task automatic to(input int k);
        while (t < k) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        ped_req_n = 2'b11;
`ifdef TLC_NIGHT_MODE_EN
        night_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_green", green, 2'b01);
        chk("rst_red", red, 2'b10);
        chk("rst_yellow", yellow, 2'b00);
        chk("rst_ped_red", ped_red, 2'b11);
        chk("rst_ped_green", ped_green, 2'b00);
        chk("rst_phase", phase, 1'b0);
        chk("rst_sec", sec_left, 8'd3);
        chk("rst_pending", ped_pending, 2'b00);
        reset = 1'b1;
        t     = 0;

        // No requests: one full rotation.
        to(3);   chk("g0_sec3", sec_left, 8'd3);
        to(4);   chk("g0_sec2", sec_left, 8'd2);
        to(8);   chk("g0_sec1", sec_left, 8'd1);
        to(11);  chk("g0_last", green, 2'b01);
        to(12);  chk("y0_yellow", yellow, 2'b01);
                 chk("y0_green", green, 2'b00);
                 chk("y0_red", red, 2'b10);
                 chk("y0_sec", sec_left, 8'd2);
        to(19);  chk("y0_last", yellow, 2'b01);
        to(20);  chk("ar0_red", red, 2'b11);
                 chk("ar0_yellow", yellow, 2'b00);
                 chk("ar0_sec", sec_left, 8'd1);
        to(23);  chk("ar0_last", red, 2'b11);
        to(24);  chk("g1_green", green, 2'b10);
                 chk("g1_red", red, 2'b01);
                 chk("g1_phase", phase, 1'b1);
                 chk("g1_sec", sec_left, 8'd3);
        to(48);  chk("rot_green", green, 2'b01);
                 chk("rot_phase", phase, 1'b0);

        // Single press on approach 0.
        to(50);  ped_req_n = 2'b10;
        to(51);  ped_req_n = 2'b11;
        to(52);  chk("press_lat2", ped_pending, 2'b00);
        to(53);  chk("press_lat3", ped_pending, 2'b01);
        to(71);  chk("ar_before_walk", red, 2'b11);
        to(72);  chk("walk_pg", ped_green, 2'b01);
                 chk("walk_pr", ped_red, 2'b10);
                 chk("walk_red", red, 2'b11);
                 chk("walk_clr", ped_pending, 2'b00);
                 chk("walk_sec", sec_left, 8'd2);
        to(79);  chk("walk_last", ped_green, 2'b01);
        to(80);  chk("after_walk_green", green, 2'b10);
                 chk("after_walk_pg", ped_green, 2'b00);
                 chk("after_walk_phase", phase, 1'b1);

        // Press coinciding with WALK entry stays pending.
        to(104); chk("g0_again", green, 2'b01);
        to(106); ped_req_n = 2'b10;
        to(107); ped_req_n = 2'b11;
        to(125); ped_req_n = 2'b10;
        to(126); ped_req_n = 2'b11;
        to(127); chk("pre_walk_pend", ped_pending, 2'b01);
        to(128); chk("sim_walk_pg", ped_green, 2'b01);
                 chk("sim_set_wins", ped_pending, 2'b01);
        to(136); chk("sim_g1", green, 2'b10);
        to(160); chk("sim_g0", green, 2'b01);
        to(184); chk("sim_walk2_pg", ped_green, 2'b01);
                 chk("sim_walk2_clr", ped_pending, 2'b00);
        to(192); chk("sim_g1b", green, 2'b10);

        // Press for approach 1 while phase 0 runs.
        to(216); chk("oth_g0", green, 2'b01);
        to(218); ped_req_n = 2'b01;
        to(219); ped_req_n = 2'b11;
        to(221); chk("oth_pend", ped_pending, 2'b10);
        to(240); chk("oth_nowalk_green", green, 2'b10);
                 chk("oth_nowalk_pg", ped_green, 2'b00);
        to(264); chk("oth_walk_pg", ped_green, 2'b10);
                 chk("oth_walk_pr", ped_red, 2'b01);
                 chk("oth_walk_phase", phase, 1'b1);
                 chk("oth_walk_clr", ped_pending, 2'b00);
        to(272); chk("oth_back_g0", green, 2'b01);
                 chk("oth_back_phase", phase, 1'b0);

        // Asynchronous reset mid-YELLOW with both requests pending.
        to(274); ped_req_n = 2'b00;
        to(275); ped_req_n = 2'b11;
        to(286); chk("mid_yellow", yellow, 2'b01);
                 chk("mid_pend", ped_pending, 2'b11);
        to(287); reset = 1'b0;
        #1;
        chk("arst_green", green, 2'b01);
        chk("arst_yellow", yellow, 2'b00);
        chk("arst_sec", sec_left, 8'd3);
        chk("arst_pend", ped_pending, 2'b00);
        chk("arst_phase", phase, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        t     = 0;
        to(11);  chk("post_rst_green", green, 2'b01);
        to(12);  chk("post_rst_yellow", yellow, 2'b01);

`ifdef TLC_NIGHT_MODE_EN
        to(13);  night_mode = 1'b1;
        to(15);  chk("night_not_yet", yellow, 2'b01);
        to(16);  chk("night_yellow", yellow, 2'b11);
                 chk("night_red", red, 2'b00);
                 chk("night_green", green, 2'b00);
                 chk("night_pr", ped_red, 2'b00);
                 chk("night_pg", ped_green, 2'b00);
                 chk("night_pend", ped_pending, 2'b00);
        to(19);  chk("night_hold", yellow, 2'b11);
        to(20);  chk("night_toggle1", yellow, 2'b00);
        to(24);  chk("night_toggle2", yellow, 2'b11);
        to(25);  night_mode = 1'b0;
        to(28);  chk("nexit_red", red, 2'b11);
                 chk("nexit_yellow", yellow, 2'b00);
                 chk("nexit_pr", ped_red, 2'b11);
                 chk("nexit_sec", sec_left, 8'd1);
        to(31);  chk("nexit_last", red, 2'b11);
        to(32);  chk("nexit_green", green, 2'b01);
                 chk("nexit_phase", phase, 1'b0);
                 chk("nexit_sec3", sec_left, 8'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised multi-approach traffic-light controller with per-approach pedestrian crossings. It replaces the single-approach light with a round-robin sequencer over `NUM_PHASES` vehicle phases. Each phase runs GREEN, YELLOW and ALLRED, plus an optional pedestrian WALK phase when that approach's button has been latched. All durations are in seconds, derived from a 1 Hz tick generated from `CLK_HZ`.

## Interface
- `CLK_HZ`, 12000000, clock cycles per second tick; ≥2
- `NUM_PHASES`, 2, number of vehicle approaches; 2..8
- `GREEN_S`, 5, green duration in seconds; 1..255
- `YELLOW_S`, 2, yellow duration in seconds; 1..255
- `ALLRED_S`, 1, all-red clearance in seconds; 1..255
- `PED_S`, 5, pedestrian walk duration in seconds; 1..255
- `clk` in 1, system clock
- `reset` in 1, asynchronous, active-low
- `ped_req_n` in `NUM_PHASES`, pedestrian buttons, active-low, asynchronous to `clk`
- `night_mode` in 1, flashing-yellow request; present only with `TLC_NIGHT_MODE_EN`
- `red`, `yellow`, `green` out `NUM_PHASES` each, vehicle lamps per approach
- `ped_red`, `ped_green` out `NUM_PHASES` each, pedestrian lamps per approach
- `phase` out `PW` = max(1, $clog2(NUM_PHASES)), current approach index
- `sec_left` out 8, remaining seconds in the current state
- `ped_pending` out `NUM_PHASES`, latched pedestrian requests

## Operation
- **Buttons:** each `ped_req_n` bit passes through a 2-FF synchroniser. A synchronised low sets `ped_pending[i]`.
- **States:** GREEN, YELLOW, ALLRED, WALK, plus NIGHT under the macro.
- **Lamps per state:**
  - GREEN: `green[phase]`=1, `red` on all other approaches.
  - YELLOW: `yellow[phase]`=1, `red` on all others.
  - ALLRED: `red` on all approaches.
  - WALK: `red` on all approaches, `ped_green[phase]`=1.
  - `ped_red[i]` = ~`ped_green[i]` in all states except NIGHT.
- **Transitions:**
  - GREEN → YELLOW → ALLRED.
  - From ALLRED: go to WALK if `ped_pending[phase]` is set; otherwise go to GREEN with `phase` = (`phase`+1) mod `NUM_PHASES`.
  - WALK → GREEN of the next phase.
- **Entry actions:**
  - `sec_left` loads that state's duration.
  - The prescaler is cleared on the transition cycle, so each state lasts exactly duration × `CLK_HZ` cycles.
  - Entering WALK clears `ped_pending[phase]`.
- **Tick:** on each tick `sec_left` decrements. On the tick where `sec_left`==1 the transition is taken instead.
- **Simultaneous set/clear:** if a synchronised press and the WALK-entry clear hit the same bit in the same cycle, set wins and the bit stays pending. Presses during WALK are latched for the next cycle of that approach.
- **Width:** the prescaler is $clog2(`CLK_HZ`) bits and counts 0..`CLK_HZ`-1. The tick is one cycle wide, at count `CLK_HZ`-1. An out-of-range parameter is an elaboration-time error.

## Timing
- **Reset values:** state GREEN, `phase`=0, `sec_left`=`GREEN_S`, prescaler 0, `ped_pending`=0, synchronisers 1. Lamps: `green[0]`=1, `red`=~1 (all approaches except 0), `yellow`=0, `ped_red`=all 1, `ped_green`=0.
- All outputs are registered. New lamp values appear in the cycle after the final tick of the old state.
- **Button latency:** press → `ped_pending` set 3 cycles later (2 synchroniser stages + latch).
- **Reset mid-operation:** an asynchronous return to the reset values; pending requests are lost.

## Configuration
- **`TLC_NIGHT_MODE_EN` defined:**
  - The `night_mode` port exists and passes through a 2-FF synchroniser.
  - When it is high, the block enters NIGHT in the next cycle from any state.
  - In NIGHT: `red`/`green` are 0, `yellow` is all 1 and toggles on every tick, `ped_red`/`ped_green` are 0, and `ped_pending` is held at 0.
  - On deassertion: go to ALLRED for `ALLRED_S`, then GREEN with `phase`=0.
- **Macro absent:** no port, no NIGHT state, no extra logic.

## Structure
- **Package `traffic_pkg`:**
  - state enum `tlc_state_e` (GREEN, YELLOW, ALLRED, WALK, NIGHT);
  - 8-bit `sec_t` typedef;
  - `MAX_PHASES`=8 constant.
- **Sub-module `tick_prescaler`:** parameter `CLK_HZ`; inputs `clk`, `reset`, synchronous `clr`; output `tick`.

## Test plan
Bench parameters for all scenarios: `CLK_HZ`=4, `NUM_PHASES`=2, `GREEN_S`=3, `YELLOW_S`=2, `ALLRED_S`=1, `PED_S`=2.
- **No requests, from reset:** `green[0]` for 12 cycles, `yellow[0]` for 8, all-red for 4, then `green[1]`. Full rotation = 48 cycles; `sec_left` follows 3,2,1 in GREEN.
- **Single press:** `ped_req_n[0]` low for 1 cycle during GREEN of phase 0 → `ped_pending[0]`=1 3 cycles later. After ALLRED, `ped_green[0]`=1 for 8 cycles and `ped_pending[0]` clears at WALK entry; then `green[1]`.
- **Simultaneous press and clear:** press lands on the WALK-entry cycle → `ped_pending[0]` stays 1 and WALK recurs on the next phase-0 cycle.
- **Press for the other approach:** `ped_req_n[1]` pressed during phase 0 → no WALK after phase 0; WALK after phase 1, then `green[0]`.
- **Reset mid-operation:** reset asserted mid-YELLOW with `ped_pending`=2'b11 → immediately `green[0]`=1, `sec_left`=3, `ped_pending`=0.
- **Night mode (`TLC_NIGHT_MODE_EN`):** `night_mode`=1 → `yellow`=2'b11 toggling every 4 cycles, `ped_*`=0. On release → 4 cycles of all-red, then `green[0]`.
